// File: rtl/md_unit.sv
// md_unit: multiply/divide unit of the E stage.
// Executes mult/multu/div/divu with a fixed multi-cycle latency, and mthi/mtlo
// in one cycle. Holds the architectural HI/LO registers and reports busy to
// the hazard unit.
//
// Ports:
//   clk        pipeline clock, rising edge
//   reset      asynchronous active-low reset, clears all state
//   start      E-stage instruction is a valid md-class op this cycle
//   md_op      0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none
//   A, B       forwarded rs / rt operands, sampled only at the accepting edge
//   md_rd      read select for md_out: 0 HI, 1 LO
//   busy       multi-cycle operation in progress (counter nonzero)
//   md_hazard  busy, or a multi-cycle op being presented this cycle
//   md_out     md_rd ? LO : HI
//   HI, LO     architectural HI / LO registers
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        md_rd,
    output logic        busy,
    output logic        md_hazard,
    output logic [31:0] md_out,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } mdOp_e;

    // Architectural and pending state
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] pendHi;
    logic [DATA_W-1:0] pendLo;
    logic              commitEn;

    logic [CNT_W-1:0]  cntNext;
    logic [DATA_W-1:0] pendHiNext;
    logic [DATA_W-1:0] pendLoNext;
    logic              commitEnNext;
    logic [DATA_W-1:0] hiNext;
    logic [DATA_W-1:0] loNext;

    // Datapath results, all from the current A/B
    logic signed [PROD_W-1:0] prodS;
    logic        [PROD_W-1:0] prodU;
    logic                     divByZero;
    logic        [DATA_W-1:0] aMag;
    logic        [DATA_W-1:0] bMag;
    logic        [DATA_W-1:0] bMagSafe;
    logic        [DATA_W-1:0] qMag;
    logic        [DATA_W-1:0] rMag;
    logic        [DATA_W-1:0] quotS;
    logic        [DATA_W-1:0] remS;
    logic        [DATA_W-1:0] bSafe;
    logic        [DATA_W-1:0] quotU;
    logic        [DATA_W-1:0] remU;
    logic                     isMultiOp;

    // Multipliers: operands extended to the full product width first
    assign prodS = PROD_W'($signed(A)) * PROD_W'($signed(B));
    assign prodU = PROD_W'(A) * PROD_W'(B);

    // Signed divide done on magnitudes so that 0x80000000 / -1 falls out as
    // 0x80000000 rem 0 without a separate overflow path. The divisor is forced
    // nonzero on divide-by-zero; the result is discarded by commitEn anyway.
    assign divByZero = (B == '0);
    assign aMag      = A[DATA_W-1] ? (~A + DATA_W'(1)) : A;
    assign bMag      = B[DATA_W-1] ? (~B + DATA_W'(1)) : B;
    assign bMagSafe  = divByZero ? DATA_W'(1) : bMag;
    assign qMag      = aMag / bMagSafe;
    assign rMag      = aMag % bMagSafe;
    assign quotS     = (A[DATA_W-1] ^ B[DATA_W-1]) ? (~qMag + DATA_W'(1)) : qMag;
    assign remS      = A[DATA_W-1] ? (~rMag + DATA_W'(1)) : rMag;

    assign bSafe     = divByZero ? DATA_W'(1) : B;
    assign quotU     = A / bSafe;
    assign remU      = A % bSafe;

    // Outputs decoded from registers / current request
    assign isMultiOp = (md_op == OP_MULT) || (md_op == OP_MULTU) ||
                       (md_op == OP_DIV)  || (md_op == OP_DIVU);
    assign busy      = (cnt != '0);
    assign md_hazard = busy | (start & isMultiOp);
    assign md_out    = md_rd ? LO : HI;

    // Next-state: count down while busy, otherwise accept a new op
    always_comb begin
        cntNext      = cnt;
        pendHiNext   = pendHi;
        pendLoNext   = pendLo;
        commitEnNext = commitEn;
        hiNext       = HI;
        loNext       = LO;

        if (busy) begin
            if (cnt == CNT_W'(1)) begin
                cntNext = '0;
                if (commitEn) begin
                    hiNext = pendHi;
                    loNext = pendLo;
                end
            end else begin
                cntNext = cnt - CNT_W'(1);
            end
        end else if (start) begin
            case (md_op)
                OP_MULT: begin
                    pendHiNext   = prodS[PROD_W-1:DATA_W];
                    pendLoNext   = prodS[DATA_W-1:0];
                    commitEnNext = 1'b1;
                    cntNext      = CNT_W'(MULT_CYCLES);
                end
                OP_MULTU: begin
                    pendHiNext   = prodU[PROD_W-1:DATA_W];
                    pendLoNext   = prodU[DATA_W-1:0];
                    commitEnNext = 1'b1;
                    cntNext      = CNT_W'(MULT_CYCLES);
                end
                OP_DIV: begin
                    pendHiNext   = remS;
                    pendLoNext   = quotS;
                    commitEnNext = ~divByZero;
                    cntNext      = CNT_W'(DIV_CYCLES);
                end
                OP_DIVU: begin
                    pendHiNext   = remU;
                    pendLoNext   = quotU;
                    commitEnNext = ~divByZero;
                    cntNext      = CNT_W'(DIV_CYCLES);
                end
                OP_MTHI: hiNext = A;
                OP_MTLO: loNext = A;
                default: ;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            pendHi   <= '0;
            pendLo   <= '0;
            commitEn <= 1'b0;
            HI       <= '0;
            LO       <= '0;
        end else begin
            cnt      <= cntNext;
            pendHi   <= pendHiNext;
            pendLo   <= pendLoNext;
            commitEn <= commitEnNext;
            HI       <= hiNext;
            LO       <= loNext;
        end
    end

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit of the E stage of the 5-stage MIPS pipeline. It executes mult/multu/div/divu with a fixed multi-cycle latency and mthi/mtlo in one cycle. It holds the architectural HI/LO registers and returns HI or LO for mfhi/mflo. It drives the hazard unit with a busy indication, so any md-class instruction waiting in D stalls F/D and flushes E until the unit is free.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu (1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (1..15)

- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- start  in  1  E-stage instruction is valid md-class this cycle (already gated by flushE)
- md_op  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (= none)
- A  in  32  forwarded rs value from the E stage
- B  in  32  forwarded rt value from the E stage
- md_rd  in  1  read select: 0 HI, 1 LO
- busy  out  1  multi-cycle operation in progress
- md_hazard  out  1  busy | (start & md_op in 1..4); consumed by the hazard unit
- md_out  out  32  md_rd ? LO : HI, combinational from the registers
- HI  out  32  architectural HI
- LO  out  32  architectural LO

## Operation
- State: HI, LO, a 4-bit counter cnt, and pending registers pend_hi and pend_lo. busy = (cnt != 0).
- Accept condition: start=1, busy=0, and md_op in 1..6. When busy=1, start is ignored for every md_op, including mthi/mtlo. The hazard unit guarantees this never happens.
- mult: {pend_hi,pend_lo} <= $signed(A)*$signed(B), 64-bit. cnt <= MULT_CYCLES.
- multu: the same product, unsigned.
- div: pend_lo <= quotient, truncated toward zero. pend_hi <= remainder, with the sign of the dividend. cnt <= DIV_CYCLES.
  - Overflow 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned quotient and remainder. cnt <= DIV_CYCLES.
- Divide by zero, signed or unsigned: busy still runs DIV_CYCLES cycles. HI and LO are left unchanged at commit (commit suppressed).
- mthi: HI <= A at the accepting edge. mtlo: LO <= A. cnt stays 0.
- Operand capture: A and B are used only at the accepting edge. Later changes have no effect.
- Commit: at the edge where cnt==1, HI <= pend_hi and LO <= pend_lo (unless suppressed), and cnt <= 0.
- At any other busy edge: cnt <= cnt-1.
- md_op 0 or 7 with start=1 does nothing.

## Timing
- Reset (reset=0, asynchronous): HI=0, LO=0, cnt=0, pend_hi=0, pend_lo=0, busy=0, md_hazard=0, md_out=0.
- Reset asserted mid-operation aborts the operation. HI and LO return to 0 and no commit occurs.
- mult accepted at edge T0: busy=1 from T0 through T0+MULT_CYCLES-1.
  - At edge T0+MULT_CYCLES, HI and LO take the product and busy falls.
  - mfhi in E during that following cycle reads the new value.
  - The same pattern applies to div/divu with DIV_CYCLES.
- md_hazard rises combinationally in the accept cycle (via start), before busy rises. It stays high until busy falls.
- mthi/mtlo: new value visible on HI/LO/md_out in the cycle after the accepting edge. busy never asserts.
- Back-to-back: a new op may be accepted in the first cycle with busy=0, i.e. right after commit.
- While busy, HI and LO keep their old values. md_out reads the old values, which the hazard unit prevents from being consumed.

## Test plan
- Reset, then start mult with A=0xFFFFFFFE (-2), B=3 -> busy high for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. md_hazard is high in the accept cycle.
- multu, A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- div, A=0xFFFFFFF9 (-7), B=2 -> busy for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. Overflow case 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- divu with B=0 after mthi A=0x1234 -> busy for 10 cycles, HI stays 0x1234. A start with mtlo during busy is ignored, so LO is unchanged.
- mtlo A=0xCAFEBABE, md_rd=1 -> md_out=0xCAFEBABE on the next cycle; busy stays 0 throughout.
- Start div, drop reset to 0 at the 4th busy cycle -> HI=LO=0 and busy=0 immediately. After release, no commit ever occurs.
